// File: rtl/mem_pkg.sv
// Shared memory-pipeline definitions: instruction field layout, lane geometry, hold FSM states.
package mem_pkg;

  localparam int unsigned INST_W      = 64;
  localparam int unsigned LANE_W      = 32;
  localparam int unsigned DATA_W      = 2 * LANE_W;
  localparam int unsigned REG_W       = 6;

  localparam int unsigned LOAD_EN_LSB = 0;
  localparam int unsigned LOAD_EN_W   = 2;
  localparam int unsigned SWAP_BIT    = 2;
  localparam int unsigned RD_WE_LSB   = 3;
  localparam int unsigned RD_WE_W     = 2;
  localparam int unsigned RD0_LSB     = 5;
  localparam int unsigned RD1_LSB     = 11;

  typedef struct packed {
    logic [LOAD_EN_W-1:0] load_en;
    logic                 swap;
    logic [RD_WE_W-1:0]   rd_we;
    logic [REG_W-1:0]     rd0;
    logic [REG_W-1:0]     rd1;
  } inst_dec_t;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_HELD  = 1'b1
  } hold_state_t;

  // Exchange the two 32-bit lanes of a 64-bit word.
  function automatic logic [DATA_W-1:0] swap_lanes(input logic [DATA_W-1:0] d);
    return {d[LANE_W-1:0], d[DATA_W-1:LANE_W]};
  endfunction

endpackage

// File: rtl/memory2_hold.sv
// Captures BRAM read data on the first stalled cycle so it survives until the stage advances.
module memory2_hold
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              used,
  input  logic [DATA_W-1:0] doutb,
  output logic [DATA_W-1:0] sel_data_c,
  output logic              hold_valid
);

  hold_state_t       state;
  hold_state_t       state_nxt;
  logic              capture;
  logic [DATA_W-1:0] hold_data;

  // State and captured data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HOLD_EMPTY;
      hold_data <= '0;
    end else begin
      state <= state_nxt;
      if (capture) hold_data <= doutb;
    end
  end

  // doutb is only valid in the first used cycle, so capture exactly on EMPTY->HELD.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      HOLD_EMPTY: begin
        if (stall && used && !flush) begin
          state_nxt = HOLD_HELD;
          capture   = 1'b1;
        end
      end
      HOLD_HELD: begin
        if (!stall || flush) state_nxt = HOLD_EMPTY;
      end
      default: state_nxt = HOLD_EMPTY;
    endcase
  end

  assign hold_valid = (state == HOLD_HELD);
  assign sel_data_c = hold_valid ? hold_data : doutb;

endmodule

// File: rtl/memory2.sv
// Second memory stage: merges load data with execute results and registers the writeback slot.
module memory2
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              memory2_used,
  input  logic [INST_W-1:0] inst,
  input  logic [DATA_W-1:0] exec_result,
  input  logic [DATA_W-1:0] doutb,
  input  logic              memory2_stall,
  input  logic              flush,
  output logic              wb_used,
  output logic [INST_W-1:0] wb_inst,
  output logic [DATA_W-1:0] wb_data,
  output logic [RD_WE_W-1:0] wb_we,
  output logic [REG_W-1:0]  wb_rd0,
  output logic [REG_W-1:0]  wb_rd1
);

  inst_dec_t         dec;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] result;
  logic              hold_valid;

  assign dec.load_en = inst[LOAD_EN_LSB +: LOAD_EN_W];
  assign dec.swap    = inst[SWAP_BIT];
  assign dec.rd_we   = inst[RD_WE_LSB +: RD_WE_W];
  assign dec.rd0     = inst[RD0_LSB +: REG_W];
  assign dec.rd1     = inst[RD1_LSB +: REG_W];

  memory2_hold u_hold (
    .clk        (clk),
    .rst        (rst),
    .stall      (memory2_stall),
    .flush      (flush),
    .used       (memory2_used),
    .doutb      (doutb),
    .sel_data_c (sel_data),
    .hold_valid (hold_valid)
  );

  assign mem_data = dec.swap ? swap_lanes(sel_data) : sel_data;

  assign result[LANE_W-1:0]      = dec.load_en[0] ? mem_data[LANE_W-1:0]      : exec_result[LANE_W-1:0];
  assign result[DATA_W-1:LANE_W] = dec.load_en[1] ? mem_data[DATA_W-1:LANE_W] : exec_result[DATA_W-1:LANE_W];

  // Writeback slot: reset beats flush beats stall; flush leaves payload fields untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_used <= 1'b0;
      wb_inst <= '0;
      wb_data <= '0;
      wb_we   <= '0;
      wb_rd0  <= '0;
      wb_rd1  <= '0;
    end else if (flush) begin
      wb_used <= 1'b0;
      wb_we   <= '0;
    end else if (!memory2_stall) begin
      wb_used <= memory2_used;
      wb_inst <= inst;
      wb_data <= result;
      wb_we   <= dec.rd_we & {RD_WE_W{memory2_used}};
      wb_rd0  <= dec.rd0;
      wb_rd1  <= dec.rd1;
    end
  end

endmodule

// File: tb/tb_memory2.sv
// Directed scoreboard bench for memory2: driver queues hand-derived expectations, monitor checks each edge.
module tb_memory2;
  import mem_pkg::*;

  localparam int unsigned M_ADV   = 0;
  localparam int unsigned M_HOLD  = 1;
  localparam int unsigned M_FLUSH = 2;
  localparam int unsigned M_RST   = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              memory2_used;
  logic [INST_W-1:0] inst;
  logic [DATA_W-1:0] exec_result;
  logic [DATA_W-1:0] doutb;
  logic              memory2_stall;
  logic              flush;
  logic              wb_used;
  logic [INST_W-1:0] wb_inst;
  logic [DATA_W-1:0] wb_data;
  logic [1:0]        wb_we;
  logic [5:0]        wb_rd0;
  logic [5:0]        wb_rd1;

  typedef struct {
    string       name;
    logic        used;
    logic [1:0]  we;
    logic        chk;
    logic [63:0] data;
    logic [63:0] inst;
    logic [5:0]  rd0;
    logic [5:0]  rd1;
  } exp_t;

  exp_t q[$];
  exp_t last_exp;
  int   total  = 0;
  int   passed = 0;

  memory2 dut (
    .clk           (clk),
    .rst           (rst),
    .memory2_used  (memory2_used),
    .inst          (inst),
    .exec_result   (exec_result),
    .doutb         (doutb),
    .memory2_stall (memory2_stall),
    .flush         (flush),
    .wb_used       (wb_used),
    .wb_inst       (wb_inst),
    .wb_data       (wb_data),
    .wb_we         (wb_we),
    .wb_rd0        (wb_rd0),
    .wb_rd1        (wb_rd1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got %0d/%0d", passed, total);
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] mk_inst(input logic [1:0] le, input logic sw, input logic [1:0] rwe,
                                          input logic [5:0] r0, input logic [5:0] r1, input logic [15:0] tag);
    logic [63:0] v;
    v = '0;
    v[LOAD_EN_LSB +: 2] = le;
    v[SWAP_BIT]         = sw;
    v[RD_WE_LSB +: 2]   = rwe;
    v[RD0_LSB +: 6]     = r0;
    v[RD1_LSB +: 6]     = r1;
    v[63:48]            = tag;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: every edge with a pending expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.name, ".used"}, 64'(wb_used), 64'(e.used));
        check({e.name, ".we"},   64'(wb_we),   64'(e.we));
        if (e.chk) begin
          check({e.name, ".data"}, wb_data, e.data);
          check({e.name, ".inst"}, wb_inst, e.inst);
          check({e.name, ".rd0"},  64'(wb_rd0), 64'(e.rd0));
          check({e.name, ".rd1"},  64'(wb_rd1), 64'(e.rd1));
        end
      end
    end
  end

  // Driver: one cycle of stimulus plus the hand-derived expectation for the following edge.
  task automatic cyc(input string nm, input int unsigned mode,
                     input logic u, input logic [1:0] le, input logic sw, input logic [1:0] rwe,
                     input logic [5:0] r0, input logic [5:0] r1, input logic [15:0] tag,
                     input logic [63:0] ex, input logic [63:0] db,
                     input logic st, input logic fl, input logic rs, input logic [63:0] exp_data);
    exp_t e;
    @(negedge clk);
    memory2_used  = u;
    inst          = mk_inst(le, sw, rwe, r0, r1, tag);
    exec_result   = ex;
    doutb         = db;
    memory2_stall = st;
    flush         = fl;
    rst           = rs;
    case (mode)
      M_ADV:   e = '{nm, u, rwe & {2{u}}, 1'b1, exp_data, inst, r0, r1};
      M_HOLD:  begin e = last_exp; e.name = nm; end
      M_FLUSH: e = '{nm, 1'b0, 2'b00, 1'b0, 64'h0, 64'h0, 6'd0, 6'd0};
      default: e = '{nm, 1'b0, 2'b00, 1'b1, 64'h0, 64'h0, 6'd0, 6'd0};
    endcase
    last_exp = e;
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; memory2_used = 1'b0; inst = '0; exec_result = '0;
    doutb = '0; memory2_stall = 1'b0; flush = 1'b0;

    cyc("reset", M_RST, 1'b1, 2'b11, 1'b0, 2'b11, 6'd9, 6'd9, 16'h0000, 64'h5, 64'h77, 1'b1, 1'b1, 1'b1, 64'h0);

    // Plain load, both lanes from memory
    cyc("load", M_ADV, 1'b1, 2'b11, 1'b0, 2'b10, 6'd3, 6'd4, 16'h0001,
        64'hFFFF_FFFF_FFFF_FFFF, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 1'b0, 64'h1111_2222_3333_4444);
    // Lane 0 loads swapped data, lane 1 keeps the execute result
    cyc("swap_mix", M_ADV, 1'b1, 2'b01, 1'b1, 2'b11, 6'd5, 6'd6, 16'h0002,
        64'h0000_0005_0000_0007, 64'hAAAA_AAAA_BBBB_BBBB, 1'b0, 1'b0, 1'b0, 64'h0000_0005_AAAA_AAAA);

    // Three stall edges; only the first cycle's doutb is meaningful
    cyc("stall1", M_HOLD, 1'b1, 2'b11, 1'b0, 2'b01, 6'd7, 6'd8, 16'h0003,
        64'h0, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 1'b0, 64'h0);
    cyc("stall2", M_HOLD, 1'b1, 2'b11, 1'b0, 2'b01, 6'd7, 6'd8, 16'h0003,
        64'h0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 1'b0, 1'b0, 64'h0);
    cyc("stall3", M_HOLD, 1'b1, 2'b11, 1'b0, 2'b01, 6'd7, 6'd8, 16'h0003,
        64'h0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 1'b0, 1'b0, 64'h0);
    cyc("stall_rel", M_ADV, 1'b1, 2'b11, 1'b0, 2'b01, 6'd7, 6'd8, 16'h0003,
        64'h0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF);

    // Flush while holding, then a fresh load must see live doutb
    cyc("fl_stall", M_HOLD, 1'b1, 2'b11, 1'b0, 2'b11, 6'd9, 6'd10, 16'h0004,
        64'h0, 64'h5555_5555_5555_5555, 1'b1, 1'b0, 1'b0, 64'h0);
    cyc("flush", M_FLUSH, 1'b1, 2'b11, 1'b0, 2'b11, 6'd9, 6'd10, 16'h0004,
        64'h0, 64'h6666_6666_6666_6666, 1'b1, 1'b1, 1'b0, 64'h0);
    cyc("post_flush", M_ADV, 1'b1, 2'b11, 1'b0, 2'b11, 6'd11, 6'd12, 16'h0005,
        64'h0, 64'h7777_7777_8888_8888, 1'b0, 1'b0, 1'b0, 64'h7777_7777_8888_8888);

    // Reset in the middle of a stall discards held data
    cyc("rs_stall", M_HOLD, 1'b1, 2'b11, 1'b0, 2'b11, 6'd13, 6'd14, 16'h0006,
        64'h0, 64'h9999_9999_9999_9999, 1'b1, 1'b0, 1'b0, 64'h0);
    cyc("rs_mid", M_RST, 1'b1, 2'b11, 1'b0, 2'b11, 6'd13, 6'd14, 16'h0006,
        64'h0, 64'h9999_9999_9999_9999, 1'b1, 1'b0, 1'b1, 64'h0);
    cyc("post_rst", M_ADV, 1'b1, 2'b11, 1'b0, 2'b11, 6'd1, 6'd2, 16'h0007,
        64'h0, 64'hABCD_0000_1234_5678, 1'b0, 1'b0, 1'b0, 64'hABCD_0000_1234_5678);

    // Bubbles: no write enables, and no capture while stalled
    cyc("bubble", M_ADV, 1'b0, 2'b00, 1'b0, 2'b11, 6'd15, 6'd16, 16'h0008,
        64'h0000_0042_0000_0043, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0000_0042_0000_0043);
    cyc("bub_stall", M_HOLD, 1'b0, 2'b11, 1'b0, 2'b11, 6'd15, 6'd16, 16'h0008,
        64'h0, 64'h1212_1212_1212_1212, 1'b1, 1'b0, 1'b0, 64'h0);
    cyc("bub_adv", M_ADV, 1'b1, 2'b11, 1'b0, 2'b11, 6'd17, 6'd18, 16'h0009,
        64'h0, 64'h3434_3434_5656_5656, 1'b0, 1'b0, 1'b0, 64'h3434_3434_5656_5656);

    @(posedge clk);
    #3;
    total++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending expected 0", q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
